// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, op-class decode,
// controller FSM states and default latencies.
package mdu_pkg;

    localparam logic [3:0] MDU_MULT  = 4'd0;
    localparam logic [3:0] MDU_MULTU = 4'd1;
    localparam logic [3:0] MDU_DIV   = 4'd2;
    localparam logic [3:0] MDU_DIVU  = 4'd3;
    localparam logic [3:0] MDU_MFHI  = 4'd4;
    localparam logic [3:0] MDU_MFLO  = 4'd5;
    localparam logic [3:0] MDU_MTHI  = 4'd6;
    localparam logic [3:0] MDU_MTLO  = 4'd7;
    localparam logic [3:0] MDU_NOP   = 4'hF;

    localparam int DEF_MULT_LAT = 5;
    localparam int DEF_DIV_LAT  = 10;
    localparam int DEF_CNT_W    = 4;

    typedef enum logic [2:0] {
        CLS_NONE,
        CLS_MUL,
        CLS_DIV,
        CLS_MT,
        CLS_MF
    } mdu_class_e;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } mdu_state_e;

    // Codes 8..14 are unassigned and behave exactly like a bubble.
    function automatic logic [3:0] mdu_norm_op(input logic [3:0] op);
        return (op[3] && (op != MDU_NOP)) ? MDU_NOP : op;
    endfunction

    function automatic mdu_class_e mdu_class(input logic [3:0] op);
        mdu_class_e cls;
        case (op)
            MDU_MULT, MDU_MULTU: cls = CLS_MUL;
            MDU_DIV,  MDU_DIVU:  cls = CLS_DIV;
            MDU_MTHI, MDU_MTLO:  cls = CLS_MT;
            MDU_MFHI, MDU_MFLO:  cls = CLS_MF;
            default:             cls = CLS_NONE;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline-side bundle of the MDU issue controller: E/D-stage requests in,
// MDU strobes and hazard/status indications out.
interface mdu_issue_ctrl_if #(
    parameter int CNT_W = 4
);
    logic             e_valid;
    logic [3:0]       e_mdu_op;
    logic             flush;
    logic             d_mdu_use;
    logic             mdu_start;
    logic [3:0]       mdu_op;
    logic             hi_we;
    logic             lo_we;
    logic             busy;
    logic [CNT_W-1:0] remain;
    logic             done;
    logic             stall_d;
    logic             err;

    modport master (
        output e_valid, e_mdu_op, flush, d_mdu_use,
        input  mdu_start, mdu_op, hi_we, lo_we, busy, remain, done, stall_d, err
    );

    modport slave (
        input  e_valid, e_mdu_op, flush, d_mdu_use,
        output mdu_start, mdu_op, hi_we, lo_we, busy, remain, done, stall_d, err
    );
endinterface

// File: rtl/mdu_lat_counter.sv
// Loadable down-counter tracking the remaining MDU busy cycles; stops at zero
// and flags the final cycle.
module mdu_lat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             last_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == CNT_W'(1));

endmodule

// File: rtl/mdu_issue_ctrl.sv
// E-stage issue and HI/LO hazard controller for the multiply/divide unit:
// gates MDU starts, tracks the in-flight latency and stalls D on MDU users.
module mdu_issue_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_LAT = DEF_MULT_LAT,
    parameter int DIV_LAT  = DEF_DIV_LAT,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    mdu_issue_ctrl_if.slave   bus
);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic             err_q;
    logic             err_d;

    logic [3:0]       op_n;
    mdu_class_e       op_cls;
    logic             busy;
    logic             issue;
    logic             start;
    logic             viol;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] remain_cnt;
    logic             cnt_last;

    assign op_n   = mdu_norm_op(bus.e_mdu_op);
    assign op_cls = mdu_class(op_n);
    assign busy   = (state_q == ST_BUSY);

    // Reset gates issue so nothing leaks to the MDU while state is being cleared.
    assign issue = bus.e_valid && !bus.flush && !busy && !reset;
    assign start = issue && ((op_cls == CLS_MUL) || (op_cls == CLS_DIV));
    assign viol  = bus.e_valid && !bus.flush && busy && (op_n != MDU_NOP) && !reset;

    assign load_val = (op_cls == CLS_DIV) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);

    mdu_lat_counter #(
        .CNT_W (CNT_W)
    ) u_lat_counter (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start),
        .load_val_i (load_val),
        .count_o    (remain_cnt),
        .last_o     (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        err_d   = err_q | viol;
        case (state_q)
            ST_IDLE: if (start)    state_d = ST_BUSY;
            ST_BUSY: if (cnt_last) state_d = ST_IDLE;
            default:               state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign bus.mdu_start = start;
    assign bus.mdu_op    = issue ? op_n : MDU_NOP;
    assign bus.hi_we     = issue && (op_n == MDU_MTHI);
    assign bus.lo_we     = issue && (op_n == MDU_MTLO);
    assign bus.busy      = busy;
    assign bus.remain    = remain_cnt;
    assign bus.done      = busy && cnt_last;
    // The issue cycle itself stalls D, so an mfhi right behind a mult waits.
    assign bus.stall_d   = bus.d_mdu_use && (busy || start);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: a reference model pushes per-cycle
// expectations into a scoreboard that is popped and checked each negedge.
module tb_mdu_issue_ctrl;
    import mdu_pkg::*;

    localparam int CNT_W = 4;

    typedef struct {
        logic       start;
        logic [3:0] op;
        logic       hi;
        logic       lo;
        logic       busy;
        logic [3:0] remain;
        logic       done;
        logic       stall;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    mdu_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t  sb[$];
    int    n_cmp  = 0;
    int    n_fail = 0;
    string sect   = "init";

    // reference model state
    int    m_rem  = 0;
    bit    m_err  = 0;

    // last observed values, used for window checks
    logic       o_busy, o_stall, o_done, o_err;
    logic [3:0] o_remain;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", sect, tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [3:0] op, input logic fl,
                        input logic du, input logic rst);
        exp_t       e;
        logic [3:0] nop;
        bit         mbusy, iss;
        bus.e_valid   = v;
        bus.e_mdu_op  = op;
        bus.flush     = fl;
        bus.d_mdu_use = du;
        reset         = rst;

        nop      = (op >= 4'd8) ? 4'hF : op;
        mbusy    = (m_rem > 0);
        iss      = v && !fl && !mbusy && !rst;
        e.start  = iss && (nop <= 4'd3);
        e.op     = iss ? nop : 4'hF;
        e.hi     = iss && (nop == 4'd6);
        e.lo     = iss && (nop == 4'd7);
        e.busy   = mbusy;
        e.remain = 4'(m_rem);
        e.done   = (m_rem == 1);
        e.stall  = du && (mbusy || e.start);
        e.err    = m_err;
        sb.push_back(e);

        @(negedge clk);
        e = sb.pop_front();
        chk("mdu_start", 32'(bus.mdu_start), 32'(e.start));
        chk("mdu_op",    32'(bus.mdu_op),    32'(e.op));
        chk("hi_we",     32'(bus.hi_we),     32'(e.hi));
        chk("lo_we",     32'(bus.lo_we),     32'(e.lo));
        chk("busy",      32'(bus.busy),      32'(e.busy));
        chk("remain",    32'(bus.remain),    32'(e.remain));
        chk("done",      32'(bus.done),      32'(e.done));
        chk("stall_d",   32'(bus.stall_d),   32'(e.stall));
        chk("err",       32'(bus.err),       32'(e.err));
        o_busy = bus.busy; o_stall = bus.stall_d; o_done = bus.done;
        o_err = bus.err; o_remain = bus.remain;
        $display("[%0t] %s v=%0b op=%0h fl=%0b du=%0b rst=%0b -> start=%0b op=%0h busy=%0b rem=%0d done=%0b stall=%0b err=%0b",
                 $time, sect, v, op, fl, du, rst, bus.mdu_start, bus.mdu_op,
                 bus.busy, bus.remain, bus.done, bus.stall_d, bus.err);

        @(posedge clk);
        if (rst) begin
            m_rem = 0;
            m_err = 0;
        end else begin
            if (v && !fl && mbusy && nop != 4'hF) m_err = 1;
            if (e.start)       m_rem = (nop <= 4'd1) ? 5 : 10;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic du);
        for (int i = 0; i < n; i++) step(1'b0, 4'hF, 1'b0, du, 1'b0);
    endtask

    initial begin
        int cnt;
        int first_rem;
        bit seen_done;

        bus.e_valid = 0; bus.e_mdu_op = 4'hF; bus.flush = 0; bus.d_mdu_use = 0;
        reset = 1;
        @(posedge clk); #1;

        sect = "reset";
        step(1'b0, 4'hF, 1'b0, 1'b1, 1'b1);
        idle(1, 1'b1);

        // mult latency: 5 busy cycles reading 5..1, done on the last
        sect = "mult_lat";
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b0);
        cnt = 0; first_rem = -1; seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
            if (o_busy) cnt++;
            if (i == 0) first_rem = int'(o_remain);
            if (i == 4) seen_done = o_done;
        end
        chk("busy_cycles", 32'(cnt), 32'd5);
        chk("first_remain", 32'(first_rem), 32'd5);
        chk("done_5th", 32'(seen_done), 32'd1);

        // divu with a D-stage MDU user: issue cycle + 10 busy cycles of stall
        sect = "divu_stall";
        step(1'b1, MDU_DIVU, 1'b0, 1'b1, 1'b0);
        cnt = (o_stall) ? 1 : 0;
        for (int i = 0; i < 11; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b1, 1'b0);
            if (i == 0) first_rem = int'(o_remain);
            if (o_stall) cnt++;
        end
        chk("stall_cycles", 32'(cnt), 32'd11);
        chk("stall_12th", 32'(o_stall), 32'd0);
        chk("div_first_remain", 32'(first_rem), 32'd10);

        // flushed mult never starts
        sect = "flush_issue";
        step(1'b1, MDU_MULT, 1'b1, 1'b1, 1'b0);
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("no_busy", 32'(o_busy), 32'd0);

        // flush while busy leaves the div running to completion
        sect = "flush_busy";
        step(1'b1, MDU_DIV, 1'b0, 1'b0, 1'b0);
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        step(1'b1, MDU_MULT, 1'b1, 1'b0, 1'b0);
        seen_done = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
            if (o_done) seen_done = 1;
        end
        chk("done_seen", 32'(seen_done), 32'd1);
        chk("flush_no_err", 32'(o_err), 32'd0);

        // move-to / move-from and an unassigned code
        sect = "mt_mf";
        step(1'b1, MDU_MTHI, 1'b0, 1'b0, 1'b0);
        step(1'b1, MDU_MTLO, 1'b0, 1'b0, 1'b0);
        step(1'b1, MDU_MFLO, 1'b0, 1'b1, 1'b0);
        step(1'b1, 4'd9,     1'b0, 1'b0, 1'b0);
        step(1'b1, MDU_MULTU, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);

        // mult injected while busy: dropped, err sticks, countdown untouched
        sect = "violation";
        step(1'b1, MDU_DIV, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b0);
        chk("rem_before_viol", 32'(o_remain), 32'd8);
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("err_set", 32'(o_err), 32'd1);
        chk("rem_after_viol", 32'(o_remain), 32'd7);
        idle(7, 1'b0);
        step(1'b1, MDU_MTHI, 1'b0, 1'b0, 1'b0);
        chk("err_held", 32'(o_err), 32'd1);
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b1);
        step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
        chk("err_cleared", 32'(o_err), 32'd0);

        // reset mid-divide, then an immediately accepted mult
        sect = "reset_mid";
        step(1'b1, MDU_DIVU, 1'b0, 1'b1, 1'b0);
        idle(2, 1'b1);
        step(1'b1, MDU_MULT, 1'b0, 1'b1, 1'b1);
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b0);
        chk("post_reset_busy", 32'(o_busy), 32'd0);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 4'hF, 1'b0, 1'b0, 1'b0);
            if (o_busy) cnt++;
        end
        chk("post_reset_mult_busy", 32'(cnt), 32'd5);

        // the done cycle still refuses a new start
        sect = "back_to_back";
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b1);
        step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue and hazard controller for the E-stage multiply/divide unit.
- Decides when an E-stage MDU instruction may start and drives the MDU start/op inputs.
- Tracks the multi-cycle latency of mult/multu/div/divu and stalls the D stage while HI/LO are pending.
- Suppresses issue when the E-stage instruction is flushed by an exception.

Parameters:
- MULT_LAT, 5: busy cycles after a mult/multu start. Must satisfy 1 <= MULT_LAT <= 2^CNT_W-1.
- DIV_LAT, 10: busy cycles after a div/divu start. Same range rule as MULT_LAT.
- CNT_W, 4: width of the remaining-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- e_valid  in  1  E-stage slot holds a real (non-bubble) instruction
- e_mdu_op  in  4  E-stage MDU op; MDU_NOP when the instruction is not an MDU op
- flush  in  1  kill the E-stage instruction this cycle (exception/eret)
- d_mdu_use  in  1  D-stage instruction is any MDU op, including mfhi/mflo/mthi/mtlo
- mdu_start  out  1  start strobe to the MDU; combinational
- mdu_op  out  4  op to the MDU; equals e_mdu_op when issue is allowed, else MDU_NOP
- hi_we  out  1  mthi issue pulse; combinational
- lo_we  out  1  mtlo issue pulse; combinational
- busy  out  1  HI/LO result pending; registered
- remain  out  CNT_W  remaining busy cycles; registered
- done  out  1  last busy cycle, HI/LO commit at the next edge; combinational from state
- stall_d  out  1  freeze the F/D stages and bubble E
- err  out  1  sticky protocol-violation flag

Behaviour:
- Issue condition: issue = e_valid && !flush && !busy.
- Op classes:
  - MUL = mult, multu.
  - DIV = div, divu.
  - MT = mthi, mtlo.
  - MF = mfhi, mflo; these never start and are passed on mdu_op only.
- mdu_start = issue && op in MUL/DIV. mdu_start is never asserted for MT, MF or MDU_NOP.
- hi_we = issue && op==mthi. lo_we = issue && op==mtlo.
- FSM states: IDLE and BUSY.
  - IDLE -> BUSY on mdu_start, loading remain with MULT_LAT or DIV_LAT according to the class.
  - In BUSY, remain decrements by 1 each cycle.
  - done = BUSY && remain==1.
  - BUSY -> IDLE on the edge where done is high; remain becomes 0.
- Timing: start at edge T gives busy=1 for cycles T+1 .. T+LAT. done is high in cycle T+LAT. busy=0 in cycle T+LAT+1.
- Back-to-back: a new MUL/DIV can start in cycle T+LAT+1 at the earliest, never in the done cycle.
- stall_d = d_mdu_use && (busy || mdu_start). The stall covers the issue cycle itself.
- stall_d does not depend on flush beyond its effect on mdu_start. A flushed MUL gives no stall.
- Flush:
  - Flush during the issue cycle: no start, no hi_we/lo_we, state unchanged.
  - Flush while BUSY: no effect. The in-flight operation completes and commits.
- Protocol violation: e_valid && !flush && busy && op!=MDU_NOP.
  - The op is dropped: no start, no we pulse.
  - err is set and held until reset.
  - remain and the state are unaffected.
- Reset, including mid-operation: state=IDLE, remain=0, busy=0, err=0. All combinational outputs become 0 / MDU_NOP because busy=0 and issue is gated by reset.
- Undefined op codes (4'b1000..4'b1110) are treated as MDU_NOP.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings: mult=0, multu=1, div=2, divu=3, mfhi=4, mflo=5, mthi=6, mtlo=7, MDU_NOP=4'b1111;
  - the class-decode function;
  - the default latency constants.
- The MDU datapath reuses the same package.
- One sub-module is natural: mdu_lat_counter, a loadable down-counter with a done flag. The FSM and hazard logic stay in the top.

Test Plan:
- Latency (mult): reset, then mult issued at edge T, d_mdu_use=0 → mdu_start=1 for one cycle; busy=1 for exactly 5 cycles; remain reads 5,4,3,2,1; done in the 5th cycle; busy=0 after.
- Latency (divu) with D hazard: divu issued with d_mdu_use=1 held high → stall_d=1 for 11 cycles (issue cycle plus 10 busy) and 0 in the 12th; remain starts at 10.
- Flush: flush=1 with a mult in E → mdu_start=0, busy stays 0, stall_d=0. Separately, flush at cycle T+2 of a div → busy continues through T+10 and done is still seen.
- mthi/mflo: mthi issue → hi_we=1 for one cycle, mdu_start=0, busy=0. mflo issue → mdu_op=5, no we pulse, no start.
- Violation: a mult forced into E during BUSY → no start, err=1 and held, the original remain countdown is unperturbed. A subsequent reset clears err.
- Reset mid-operation: reset at cycle T+3 of a div → next cycle busy=0, remain=0, stall_d=0. A new mult accepted immediately after gives a 5-cycle busy.
